// File: rtl/fb_pkg.sv
// Framebuffer write scheduler shared types.
// Fill FSM states and framebuffer geometry.
package fb_pkg;
  localparam int FB_ADDR_W    = 15;
  localparam int FB_VIS_WORDS = 9600;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FS,
    FILL,
    DONE
  } fill_state_t;
endpackage

// File: rtl/fb_fill_engine.sv
// Fill/clear engine: FSM, word counter, latched pattern.
// Requests one word per cycle while filling.
module fb_fill_engine
  import fb_pkg::*;
#(
  parameter int ADDR_W   = FB_ADDR_W,
  parameter int FB_WORDS = FB_VIS_WORDS
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr_start,
  input  logic              clr_abort,
  input  logic              clr_sync,
  input  logic [31:0]       clr_pattern,
  input  logic              frame_start,
  input  logic              fill_gnt,
  output logic              fill_req,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [31:0]       fill_data,
  output logic              clr_busy,
  output logic              clr_done
);

  fill_state_t       state;
  fill_state_t       state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [31:0]       pat;
  logic              last;

  assign last = (cnt == ADDR_W'(FB_WORDS - 1));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; abort beats a simultaneous frame_start
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (clr_start)
          state_nxt = clr_sync ? WAIT_FS : FILL;
      end
      WAIT_FS: begin
        if (clr_abort)        state_nxt = DONE;
        else if (frame_start) state_nxt = FILL;
      end
      FILL: begin
        if (clr_abort || (fill_gnt && last))
          state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
    endcase
  end

  // Word counter advances only on a fill grant
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)           cnt <= '0;
    else if (state != FILL) cnt <= '0;
    else if (fill_gnt)      cnt <= last ? '0 : cnt + ADDR_W'(1);
  end

  // Pattern captured only on an accepted start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        pat <= '0;
    else if (state == IDLE && clr_start) pat <= clr_pattern;
  end

  assign fill_req  = (state == FILL);
  assign fill_addr = cnt;
  assign fill_data = pat;
  assign clr_busy  = (state != IDLE);
  assign clr_done  = (state == DONE);

endmodule

// File: rtl/fb_write_scheduler.sv
// Framebuffer write-port owner: arbitrates host writes
// against the fill engine with a guaranteed fill slot.
module fb_write_scheduler
  import fb_pkg::*;
#(
  parameter int ADDR_W    = FB_ADDR_W,
  parameter int FB_WORDS  = FB_VIS_WORDS,
  parameter int FILL_SLOT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              host_cs,
  input  logic              host_write,
  input  logic [ADDR_W-1:0] host_address,
  input  logic [31:0]       host_writedata,
  output logic              host_waitreq,
  input  logic              clr_start,
  input  logic              clr_abort,
  input  logic              clr_sync,
  input  logic [31:0]       clr_pattern,
  input  logic              frame_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              fb_wren,
  output logic [ADDR_W-1:0] fb_wraddress,
  output logic [31:0]       fb_data
);

  localparam int SW = $clog2(FILL_SLOT + 1);

  logic              fill_req;
  logic              fill_gnt;
  logic [ADDR_W-1:0] fill_addr;
  logic [31:0]       fill_data;
  logic              host_req;
  logic              host_gnt;
  logic              slot_due;
  logic [SW-1:0]     starve;

  fb_fill_engine #(
    .ADDR_W   (ADDR_W),
    .FB_WORDS (FB_WORDS)
  ) u_fill (
    .clk         (clk),
    .reset_n     (reset_n),
    .clr_start   (clr_start),
    .clr_abort   (clr_abort),
    .clr_sync    (clr_sync),
    .clr_pattern (clr_pattern),
    .frame_start (frame_start),
    .fill_gnt    (fill_gnt),
    .fill_req    (fill_req),
    .fill_addr   (fill_addr),
    .fill_data   (fill_data),
    .clr_busy    (clr_busy),
    .clr_done    (clr_done)
  );

  assign host_req     = host_cs & host_write;
  assign slot_due     = fill_req & (starve == SW'(FILL_SLOT));
  assign fill_gnt     = fill_req & (~host_req | slot_due);
  assign host_gnt     = host_req & ~fill_gnt;
  assign host_waitreq = host_req & slot_due;

  // Consecutive host grants while a fill is pending
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  starve <= '0;
    else if (!fill_req || fill_gnt) starve <= '0;
    else if (host_gnt)             starve <= starve + SW'(1);
  end

  // Registered write port; address/data hold when idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fb_wren      <= 1'b0;
      fb_wraddress <= '0;
      fb_data      <= '0;
    end else begin
      fb_wren <= host_gnt | fill_gnt;
      if (fill_gnt) begin
        fb_wraddress <= fill_addr;
        fb_data      <= fill_data;
      end else if (host_gnt) begin
        fb_wraddress <= host_address;
        fb_data      <= host_writedata;
      end
    end
  end

endmodule
